// File: rtl/apm_match_tracker.sv
// apm_match_tracker
// Consumes one APM result word per text window on a valid/ready stream. Over a
// frame (windows up to and including the one flagged y_last) it keeps the best
// score, the index and location bitmap of that window, the number of windows
// with any hit and the total number of match locations. When the frame closes,
// one registered summary is offered on a valid/ready result port.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   y_valid/y_ready   APM word handshake; y_ready is high only while accumulating
//   y_data            APM Y: [28:24] score, [16:0] location bitmap
//   y_last            final window of the frame
//   res_valid/ready   frame summary handshake
//   res_best_score    highest score in the frame
//   res_best_win      window index of the first window holding that score
//   res_best_locs     location bitmap of that window
//   res_hit_count     windows with any location bit set (saturating)
//   res_loc_total     total location bits set over the frame (saturating)
//   res_overflow      more windows arrived than the window index can name
module apm_match_tracker #(
    parameter int unsigned WIN_CNT_W = 8,
    parameter int unsigned SCORE_W   = 5,
    parameter int unsigned LOC_W     = 17
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           y_valid,
    output logic                           y_ready,
    input  logic [31:0]                    y_data,
    input  logic                           y_last,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [SCORE_W-1:0]             res_best_score,
    output logic [WIN_CNT_W-1:0]           res_best_win,
    output logic [LOC_W-1:0]               res_best_locs,
    output logic [WIN_CNT_W-1:0]           res_hit_count,
    output logic [WIN_CNT_W+SCORE_W-1:0]   res_loc_total,
    output logic                           res_overflow
);

    localparam int unsigned TOT_W     = WIN_CNT_W + SCORE_W;
    localparam int unsigned SUM_W     = TOT_W + 1;
    localparam int unsigned POP_W     = $clog2(LOC_W + 1);
    localparam int unsigned SCORE_LSB = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Frame accumulators
    logic                 first_q,      first_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [WIN_CNT_W-1:0] best_win_q,   best_win_d;
    logic [LOC_W-1:0]     best_locs_q,  best_locs_d;
    logic [WIN_CNT_W-1:0] hit_q,        hit_d;
    logic [TOT_W-1:0]     tot_q,        tot_d;
    logic [WIN_CNT_W-1:0] idx_q,        idx_d;
    logic                 idx_full_q,   idx_full_d;
    logic                 ovf_q,        ovf_d;

    // Next values of the registered ports
    logic                 y_ready_d;
    logic                 res_valid_d;
    logic [SCORE_W-1:0]   res_best_score_d;
    logic [WIN_CNT_W-1:0] res_best_win_d;
    logic [LOC_W-1:0]     res_best_locs_d;
    logic [WIN_CNT_W-1:0] res_hit_count_d;
    logic [TOT_W-1:0]     res_loc_total_d;
    logic                 res_overflow_d;

    logic [SCORE_W-1:0]   score;
    logic [LOC_W-1:0]     locs;
    logic [POP_W-1:0]     pop;
    logic [SUM_W-1:0]     tot_sum;
    logic                 accept;

    // Fields outside score and locations carry no meaning here
    logic unused_y_bits;
    assign unused_y_bits = ^{y_data[31:SCORE_LSB+SCORE_W], y_data[SCORE_LSB-1:LOC_W]};

    assign score  = y_data[SCORE_LSB +: SCORE_W];
    assign locs   = y_data[LOC_W-1:0];
    // y_ready mirrors state==ACCUM, so this is a beat taken this cycle
    assign accept = y_valid && y_ready;

    // Population count of the location bitmap
    always_comb begin
        pop = '0;
        for (int i = 0; i < LOC_W; i++) begin
            pop = pop + POP_W'(locs[i]);
        end
    end

    // Next state, accumulator update and summary capture
    always_comb begin
        state_d          = state_q;
        first_d          = first_q;
        best_score_d     = best_score_q;
        best_win_d       = best_win_q;
        best_locs_d      = best_locs_q;
        hit_d            = hit_q;
        tot_d            = tot_q;
        idx_d            = idx_q;
        idx_full_d       = idx_full_q;
        ovf_d            = ovf_q;
        res_best_score_d = res_best_score;
        res_best_win_d   = res_best_win;
        res_best_locs_d  = res_best_locs;
        res_hit_count_d  = res_hit_count;
        res_loc_total_d  = res_loc_total;
        res_overflow_d   = res_overflow;
        tot_sum          = '0;

        unique case (state_q)
            IDLE: begin
                // Fresh frame: the next beat is the first one
                first_d      = 1'b1;
                best_score_d = '0;
                best_win_d   = '0;
                best_locs_d  = '0;
                hit_d        = '0;
                tot_d        = '0;
                idx_d        = '0;
                idx_full_d   = 1'b0;
                ovf_d        = 1'b0;
                state_d      = ACCUM;
            end

            ACCUM: begin
                if (accept) begin
                    // Strict compare keeps the earliest window on ties
                    if (first_q || (score > best_score_q)) begin
                        best_score_d = score;
                        best_win_d   = idx_q;
                        best_locs_d  = locs;
                    end
                    first_d = 1'b0;

                    if ((|locs) && (hit_q != {WIN_CNT_W{1'b1}})) begin
                        hit_d = hit_q + WIN_CNT_W'(1);
                    end

                    tot_sum = {1'b0, tot_q} + SUM_W'(pop);
                    tot_d   = tot_sum[TOT_W] ? {TOT_W{1'b1}} : tot_sum[TOT_W-1:0];

                    // The last index is usable once; any beat beyond it overflows
                    if (idx_q == {WIN_CNT_W{1'b1}}) begin
                        if (idx_full_q) begin
                            ovf_d = 1'b1;
                        end
                        idx_full_d = 1'b1;
                    end else begin
                        idx_d = idx_q + WIN_CNT_W'(1);
                    end

                    if (y_last) begin
                        state_d          = REPORT;
                        res_best_score_d = best_score_d;
                        res_best_win_d   = best_win_d;
                        res_best_locs_d  = best_locs_d;
                        res_hit_count_d  = hit_d;
                        res_loc_total_d  = tot_d;
                        res_overflow_d   = ovf_d;
                    end
                end
            end

            REPORT: begin
                if (res_valid && res_ready) begin
                    state_d          = IDLE;
                    res_best_score_d = '0;
                    res_best_win_d   = '0;
                    res_best_locs_d  = '0;
                    res_hit_count_d  = '0;
                    res_loc_total_d  = '0;
                    res_overflow_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        y_ready_d   = (state_d == ACCUM);
        res_valid_d = (state_d == REPORT);
    end

    // State, accumulators and registered ports
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            first_q        <= 1'b0;
            best_score_q   <= '0;
            best_win_q     <= '0;
            best_locs_q    <= '0;
            hit_q          <= '0;
            tot_q          <= '0;
            idx_q          <= '0;
            idx_full_q     <= 1'b0;
            ovf_q          <= 1'b0;
            y_ready        <= 1'b0;
            res_valid      <= 1'b0;
            res_best_score <= '0;
            res_best_win   <= '0;
            res_best_locs  <= '0;
            res_hit_count  <= '0;
            res_loc_total  <= '0;
            res_overflow   <= 1'b0;
        end else begin
            state_q        <= state_d;
            first_q        <= first_d;
            best_score_q   <= best_score_d;
            best_win_q     <= best_win_d;
            best_locs_q    <= best_locs_d;
            hit_q          <= hit_d;
            tot_q          <= tot_d;
            idx_q          <= idx_d;
            idx_full_q     <= idx_full_d;
            ovf_q          <= ovf_d;
            y_ready        <= y_ready_d;
            res_valid      <= res_valid_d;
            res_best_score <= res_best_score_d;
            res_best_win   <= res_best_win_d;
            res_best_locs  <= res_best_locs_d;
            res_hit_count  <= res_hit_count_d;
            res_loc_total  <= res_loc_total_d;
            res_overflow   <= res_overflow_d;
        end
    end

endmodule

// File: tb/tb_apm_match_tracker.sv
// Directed bench for apm_match_tracker: a default-width instance and a
// 2-bit window-counter instance share one stimulus stream; a frame-level model
// predicts handshake timing and summaries, plus literal spot checks.
module tb_apm_match_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        y_valid;
    logic [31:0] y_data;
    logic        y_last;
    logic        res_ready;

    logic        y_ready8, res_valid8, res_ovf8;
    logic [4:0]  res_score8;
    logic [7:0]  res_win8, res_hit8;
    logic [16:0] res_locs8;
    logic [12:0] res_tot8;

    logic        y_ready2, res_valid2, res_ovf2;
    logic [4:0]  res_score2;
    logic [1:0]  res_win2, res_hit2;
    logic [16:0] res_locs2;
    logic [6:0]  res_tot2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    apm_match_tracker dut8 (
        .clk(clk), .rst_n(rst_n),
        .y_valid(y_valid), .y_ready(y_ready8), .y_data(y_data), .y_last(y_last),
        .res_valid(res_valid8), .res_ready(res_ready),
        .res_best_score(res_score8), .res_best_win(res_win8), .res_best_locs(res_locs8),
        .res_hit_count(res_hit8), .res_loc_total(res_tot8), .res_overflow(res_ovf8)
    );

    apm_match_tracker #(.WIN_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .y_valid(y_valid), .y_ready(y_ready2), .y_data(y_data), .y_last(y_last),
        .res_valid(res_valid2), .res_ready(res_ready),
        .res_best_score(res_score2), .res_best_win(res_win2), .res_best_locs(res_locs2),
        .res_hit_count(res_hit2), .res_loc_total(res_tot2), .res_overflow(res_ovf2)
    );

    typedef struct {
        int score;
        int win;
        int locs;
        int hit;
        int tot;
        int ovf;
    } summ_t;

    int q_score[$];
    int q_locs[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame summary straight from the list of accepted beats
    function automatic summ_t summarize(input int w);
        summ_t s;
        int max_idx = (1 << w) - 1;
        int tot_max = (1 << (w + 5)) - 1;
        int hits = 0;
        int tot  = 0;
        s = '{default: 0};
        for (int i = 0; i < q_score.size(); i++) begin
            if (i == 0 || q_score[i] > s.score) begin
                s.score = q_score[i];
                s.win   = (i > max_idx) ? max_idx : i;
                s.locs  = q_locs[i];
            end
            if (q_locs[i] != 0) hits++;
            tot += $countones(q_locs[i]);
        end
        s.hit = (hits > max_idx) ? max_idx : hits;
        s.tot = (tot > tot_max) ? tot_max : tot;
        s.ovf = (q_score.size() > max_idx + 1) ? 1 : 0;
        return s;
    endfunction

    task automatic chk_res(input string tag, input bit rep, input summ_t e,
                           input int sc, input int wn, input int lc,
                           input int ht, input int tt, input int ov);
        summ_t z;
        z = '{default: 0};
        if (!rep) e = z;
        chk({tag, ".best_score"}, sc, e.score);
        chk({tag, ".best_win"},   wn, e.win);
        chk({tag, ".best_locs"},  lc, e.locs);
        chk({tag, ".hit_count"},  ht, e.hit);
        chk({tag, ".loc_total"},  tt, e.tot);
        chk({tag, ".overflow"},   ov, e.ovf);
    endtask

    // Cycle compare against the frame-level model; model then advances to the next edge
    bit    started = 1'b0;
    bit    in_rep  = 1'b0;
    int    since   = 0;
    summ_t e8, e2;

    always @(negedge clk) begin
        if (started) begin
            chk("y_ready8",   int'(y_ready8),   int'(!in_rep && since >= 1));
            chk("y_ready2",   int'(y_ready2),   int'(!in_rep && since >= 1));
            chk("res_valid8", int'(res_valid8), int'(in_rep));
            chk("res_valid2", int'(res_valid2), int'(in_rep));
            chk_res("cyc8", in_rep, e8, res_score8, res_win8, res_locs8, res_hit8, res_tot8, res_ovf8);
            chk_res("cyc2", in_rep, e2, res_score2, res_win2, res_locs2, res_hit2, res_tot2, res_ovf2);
        end
        if (!rst_n) begin
            started = 1'b1;
            in_rep  = 1'b0;
            since   = 0;
            q_score.delete();
            q_locs.delete();
        end else if (started) begin
            if (in_rep) begin
                if (res_ready) begin
                    in_rep = 1'b0;
                    since  = 0;
                end
            end else if (since >= 1) begin
                if (y_valid) begin
                    q_score.push_back(int'(y_data[28:24]));
                    q_locs.push_back(int'(y_data[16:0]));
                    if (y_last) begin
                        e8 = summarize(8);
                        e2 = summarize(2);
                        q_score.delete();
                        q_locs.delete();
                        in_rep = 1'b1;
                    end
                end
            end else begin
                since++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is taken
    task automatic send(input int score, input int locs, input bit last);
        int n = 0;
        y_valid = 1'b1;
        y_data  = {3'b101, 5'(score), 7'h55, 17'(locs)};
        y_last  = last;
        do begin
            @(negedge clk);
            n++;
        end while (!y_ready8 && n < 50);
        chk("send_ready_timeout", int'(y_ready8), 1);
        step();
        y_valid = 1'b0;
        y_last  = 1'b0;
    endtask

    // Returns at the negedge where the summary is first visible
    task automatic wait_res(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid8 && lat < 50);
        chk("res_valid_timeout", int'(res_valid8), 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lat;

    initial begin
        // Reset with live, garbage input
        rst_n     = 1'b0;
        y_valid   = 1'b1;
        y_data    = 32'hFFFF_FFFF;
        y_last    = 1'b1;
        res_ready = 1'b1;
        repeat (3) step();
        chk("rst.y_ready",   int'(y_ready8),   0);
        chk("rst.res_valid", int'(res_valid8), 0);
        chk("rst.res_tot",   int'(res_tot8),   0);
        y_valid   = 1'b0;
        y_last    = 1'b0;
        res_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("rel.ready_cycle1", int'(y_ready8), 0);
        @(negedge clk);
        chk("rel.ready_cycle2", int'(y_ready8), 1);
        step();

        // Single-beat frame
        send(16, 17'h00001, 1'b1);
        wait_res(lat);
        chk("t2.latency",    lat,               1);
        chk("t2.best_score", int'(res_score8),  16);
        chk("t2.best_win",   int'(res_win8),    0);
        chk("t2.best_locs",  int'(res_locs8),   1);
        chk("t2.hit_count",  int'(res_hit8),    1);
        chk("t2.loc_total",  int'(res_tot8),    1);
        chk("t2.overflow",   int'(res_ovf8),    0);
        step();
        handshake();

        // Tie keeps earliest window
        send(3, 0, 1'b0);
        send(9, 17'h0AAAA, 1'b0);
        send(9, 17'h00001, 1'b1);
        wait_res(lat);
        chk("t3.best_score", int'(res_score8), 9);
        chk("t3.best_win",   int'(res_win8),   1);
        chk("t3.best_locs",  int'(res_locs8),  32'h0AAAA);
        chk("t3.hit_count",  int'(res_hit8),   2);
        chk("t3.loc_total",  int'(res_tot8),   9);
        step();

        // Backpressure on the result port with input offered
        y_valid = 1'b1;
        y_data  = {3'b000, 5'd31, 7'h00, 17'h1FFFF};
        y_last  = 1'b1;
        repeat (5) step();
        chk("t4.held_score", int'(res_score8), 9);
        chk("t4.y_ready",    int'(y_ready8),   0);
        y_valid = 1'b0;
        y_last  = 1'b0;
        handshake();
        @(negedge clk);
        chk("t4.bubble_ready", int'(y_ready8), 0);
        @(negedge clk);
        chk("t4.ready_back",   int'(y_ready8), 1);
        step();
        send(5, 17'h00001, 1'b0);
        send(7, 17'h00002, 1'b1);
        wait_res(lat);
        chk("t4.next_win",   int'(res_win8),   1);
        chk("t4.next_score", int'(res_score8), 7);
        step();
        handshake();

        // Reset mid-frame discards the partial frame
        send(20, 17'h1FFFF, 1'b0);
        send(20, 17'h00003, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        send(4, 17'h00003, 1'b1);
        wait_res(lat);
        chk("t5.best_score", int'(res_score8), 4);
        chk("t5.best_win",   int'(res_win8),   0);
        chk("t5.hit_count",  int'(res_hit8),   1);
        chk("t5.loc_total",  int'(res_tot8),   2);
        step();
        handshake();

        // Window index saturation on the 2-bit instance
        send(1, 17'h1FFFF, 1'b0);
        send(2, 17'h1FFFF, 1'b0);
        send(3, 17'h1FFFF, 1'b0);
        send(4, 17'h1FFFF, 1'b0);
        send(31, 17'h1FFFF, 1'b0);
        send(5, 17'h1FFFF, 1'b1);
        wait_res(lat);
        chk("t6.w2.overflow",   int'(res_ovf2),   1);
        chk("t6.w2.best_win",   int'(res_win2),   3);
        chk("t6.w2.best_score", int'(res_score2), 31);
        chk("t6.w2.hit_count",  int'(res_hit2),   3);
        chk("t6.w2.loc_total",  int'(res_tot2),   102);
        chk("t6.w8.best_win",   int'(res_win8),   4);
        chk("t6.w8.overflow",   int'(res_ovf8),   0);
        chk("t6.w8.hit_count",  int'(res_hit8),   6);
        step();
        handshake();

        // Zero scores: first beat still loads; loc_total saturates on the narrow instance
        for (int i = 0; i < 8; i++) begin
            send(0, (i == 0) ? 17'h1FFFF : 17'h0FFFF + 17'h10000, i == 7);
        end
        wait_res(lat);
        chk("t7.w8.best_locs", int'(res_locs8), 32'h1FFFF);
        chk("t7.w8.best_win",  int'(res_win8),  0);
        chk("t7.w8.loc_total", int'(res_tot8),  136);
        chk("t7.w2.loc_total", int'(res_tot2),  127);
        chk("t7.w2.overflow",  int'(res_ovf2),  1);
        step();
        handshake();

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
